// File: rtl/decim_sched.sv
// decim_sched: keep-one-in-N scheduler with start/stop sequencing, phase-aligned ratio updates and overrun accounting.
// Build option DECIM_SCHED_ALIGN_EN adds the sync_in phase-realignment input.
module decim_sched #(
    parameter int DATA_W        = 16,
    parameter int RATIO_W       = 4,
    parameter int DEFAULT_RATIO = 6
) (
    input  logic               CLOCK_50,
    input  logic               reset_n,
    input  logic               enable,
    input  logic [RATIO_W-1:0] cfg_ratio,
    input  logic               cfg_load,
    input  logic               in_valid,
    input  logic [DATA_W-1:0]  in_data,
`ifdef DECIM_SCHED_ALIGN_EN
    input  logic               sync_in,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic               busy,
    output logic [RATIO_W-1:0] phase,
    output logic               overrun,
    output logic [7:0]         ovr_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    // Ratios below 2 all mean pass-through, so they are stored as 1.
    function automatic logic [RATIO_W-1:0] clamp_ratio(input logic [RATIO_W-1:0] r);
        logic [RATIO_W-1:0] v;
        if (r < RATIO_W'(2)) begin
            v = RATIO_W'(1);
        end else begin
            v = r;
        end
        return v;
    endfunction

    localparam logic [RATIO_W-1:0] RESET_RATIO =
        (DEFAULT_RATIO < 2) ? RATIO_W'(1) : RATIO_W'(DEFAULT_RATIO);

    state_t              state_r;
    state_t              state_next_s;
    logic [RATIO_W-1:0]  phase_r;
    logic [RATIO_W-1:0]  phase_next_s;
    logic [RATIO_W-1:0]  active_r;
    logic [RATIO_W-1:0]  active_next_s;
    logic [RATIO_W-1:0]  pend_r;
    logic                pend_flag_r;
    logic [RATIO_W-1:0]  eff_ratio_s;
    logic                apply_s;
    logic                capture_s;
    logic                handshake_s;
    logic                ovr_event_s;
    logic                sync_s;
    logic                busy_r;
    logic                out_valid_r;
    logic [DATA_W-1:0]   out_data_r;
    logic                overrun_r;
    logic [7:0]          ovr_count_r;

`ifdef DECIM_SCHED_ALIGN_EN
    assign sync_s = sync_in;
`else
    assign sync_s = 1'b0;
`endif

    assign eff_ratio_s = pend_flag_r ? pend_r : active_r;
    assign handshake_s = out_valid_r & out_ready;
    assign ovr_event_s = capture_s & out_valid_r & ~out_ready;

    // Next-state, phase advance, capture decision and pending-ratio application.
    always_comb begin
        state_next_s = state_r;
        phase_next_s = phase_r;
        apply_s      = 1'b0;
        capture_s    = 1'b0;
        case (state_r)
            IDLE: begin
                apply_s      = pend_flag_r;
                phase_next_s = RATIO_W'(0);
                if (enable) begin
                    state_next_s = ARM;
                end else begin
                    state_next_s = IDLE;
                end
            end
            ARM: begin
                apply_s      = pend_flag_r;
                phase_next_s = RATIO_W'(0);
                state_next_s = RUN;
            end
            RUN: begin
                if (sync_s) begin
                    // A realigned sample counts as phase 0 under the newly effective ratio.
                    apply_s = pend_flag_r;
                    if (in_valid) begin
                        if (eff_ratio_s == RATIO_W'(1)) begin
                            capture_s    = 1'b1;
                            phase_next_s = RATIO_W'(0);
                        end else begin
                            phase_next_s = RATIO_W'(1);
                        end
                    end else begin
                        phase_next_s = RATIO_W'(0);
                    end
                end else if (in_valid) begin
                    if (phase_r == active_r - RATIO_W'(1)) begin
                        capture_s    = 1'b1;
                        phase_next_s = RATIO_W'(0);
                        apply_s      = pend_flag_r;
                    end else begin
                        phase_next_s = phase_r + RATIO_W'(1);
                    end
                end else begin
                    phase_next_s = phase_r;
                end
                if (enable) begin
                    state_next_s = RUN;
                end else begin
                    state_next_s = DRAIN;
                end
            end
            DRAIN: begin
                if (!out_valid_r || handshake_s) begin
                    phase_next_s = RATIO_W'(0);
                    if (enable) begin
                        state_next_s = ARM;
                    end else begin
                        state_next_s = IDLE;
                    end
                end else begin
                    state_next_s = DRAIN;
                end
            end
            default: begin
                state_next_s = IDLE;
                phase_next_s = RATIO_W'(0);
            end
        endcase
        if (apply_s) begin
            active_next_s = pend_r;
        end else begin
            active_next_s = active_r;
        end
    end

    // Sequencer state, phase counter and ratio registers.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= IDLE;
            phase_r     <= RATIO_W'(0);
            active_r    <= RESET_RATIO;
            pend_r      <= RESET_RATIO;
            pend_flag_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r  <= state_next_s;
            phase_r  <= phase_next_s;
            active_r <= active_next_s;
            busy_r   <= (state_next_s != IDLE);
            // A fresh load wins over clearing the flag on the same edge.
            if (cfg_load) begin
                pend_r      <= clamp_ratio(cfg_ratio);
                pend_flag_r <= 1'b1;
            end else if (apply_s) begin
                pend_flag_r <= 1'b0;
            end else begin
                pend_flag_r <= pend_flag_r;
            end
        end
    end

    // Output holding register, overrun pulse and saturating overrun counter.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_r <= 1'b0;
            out_data_r  <= DATA_W'(0);
            overrun_r   <= 1'b0;
            ovr_count_r <= 8'd0;
        end else begin
            if (capture_s) begin
                out_valid_r <= 1'b1;
                out_data_r  <= in_data;
            end else if (handshake_s) begin
                out_valid_r <= 1'b0;
            end else begin
                out_valid_r <= out_valid_r;
            end
            overrun_r <= ovr_event_s;
            if (ovr_event_s && (ovr_count_r != 8'hFF)) begin
                ovr_count_r <= ovr_count_r + 8'd1;
            end else begin
                ovr_count_r <= ovr_count_r;
            end
        end
    end

    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign busy      = busy_r;
    assign phase     = phase_r;
    assign overrun   = overrun_r;
    assign ovr_count = ovr_count_r;

endmodule
